// File: rtl/dmem_stage_pkg.sv
// Shared constants for the data-memory stage: access sizes and byte-lane masks.
package dmem_stage_pkg;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

    localparam logic [3:0] LANES_ALL = 4'b1111;
    localparam logic [3:0] LANES_LO  = 4'b0011;
    localparam logic [3:0] LANES_HI  = 4'b1100;

    // Byte lanes touched by a store of the given size; upper selects addr[1].
    function automatic logic [3:0] lane_mask(input logic size, input logic upper);
        if (size == SIZE_WORD) begin
            return LANES_ALL;
        end
        return upper ? LANES_HI : LANES_LO;
    endfunction

endpackage

// File: rtl/dmem_stage_if.sv
// Request/response bundle between the pipeline (master) and the data-memory stage (slave).
// en advances the pipeline; a request is taken on a rising edge with en=1 and
// mem_re or mem_we set. rvalid qualifies rdata/wc/half_word_t one cycle later.
interface dmem_stage_if;

    logic        en;
    logic        mem_re;
    logic        mem_we;
    logic        half;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wc;
    logic        half_word_t;
    logic        rvalid;
    logic        misalign;

    modport master (
        output en, mem_re, mem_we, half, addr, wdata,
        input  rdata, wc, half_word_t, rvalid, misalign
    );

    modport slave (
        input  en, mem_re, mem_we, half, addr, wdata,
        output rdata, wc, half_word_t, rvalid, misalign
    );

endinterface

// File: rtl/dmem_stage_ram.sv
// Single-port synchronous data RAM with per-byte write enables and read-first output.
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rdata_q;

    // Read samples the array before this edge's write lands, giving read-first data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_stage.sv
// MIPS data-memory stage: alignment check, byte-lane stores, synchronous loads with
// the halfword select and size registered alongside the read word.
module dmem_stage
    import dmem_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    dmem_stage_if.slave  dmem
);

    logic [ADDR_W-1:0] word_idx;
    logic              req;
    logic              misaligned;
    logic              go;
    logic              rd_en;
    logic [3:0]        wr_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              unused_addr;

    logic wc_q;
    logic half_q;
    logic rvalid_q;
    logic misalign_q;
    logic loaded_q;

    assign word_idx    = dmem.addr[ADDR_W+1:2];
    assign unused_addr = ^dmem.addr[31:ADDR_W+2];

    assign req        = dmem.en & ~rst & (dmem.mem_re | dmem.mem_we);
    assign misaligned = (dmem.half == SIZE_HALF) ? dmem.addr[0] : (dmem.addr[1:0] != 2'b00);
    assign go         = req & ~misaligned;
    assign rd_en      = go & dmem.mem_re;
    assign wr_be      = (go & dmem.mem_we) ? lane_mask(dmem.half, dmem.addr[1]) : 4'b0000;
    // Halfword data is replicated so either lane pair picks it up.
    assign ram_wdata  = (dmem.half == SIZE_HALF) ? {2{dmem.wdata[15:0]}} : dmem.wdata;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .re_i    (rd_en),
        .we_i    (wr_be),
        .addr_i  (word_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wc_q       <= 1'b0;
            half_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            loaded_q   <= 1'b0;
        end else if (dmem.en) begin
            rvalid_q   <= rd_en;
            misalign_q <= req & misaligned;
            if (rd_en) begin
                wc_q     <= dmem.addr[1];
                half_q   <= dmem.half;
                loaded_q <= 1'b1;
            end
        end
    end

    // The RAM read register has no reset, so rdata reads as zero until a load follows reset.
    assign dmem.rdata       = loaded_q ? ram_rdata : 32'h0;
    assign dmem.wc          = wc_q;
    assign dmem.half_word_t = half_q;
    assign dmem.rvalid      = rvalid_q;
    assign dmem.misalign    = misalign_q;

endmodule

// File: tb/tb_dmem_stage.sv
// Randomized and directed bench for dmem_stage against a word-array reference model.
module tb_dmem_stage;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0] rdata;
        logic        wc;
        logic        hwt;
        logic        rvalid;
        logic        mis;
    } resp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_stage_if bus ();

    dmem_stage #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dmem (bus)
    );

    resp_t       exp_q[$];
    logic [31:0] ref_mem [0:DEPTH-1];
    resp_t       ref_out;
    int          total = 0;
    int          bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    // Reference: outputs follow the load/store rules on a plain word array.
    task automatic model(input logic r, input logic e, input logic re, input logic we,
                         input logic hf, input logic [31:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a[ADDR_W+1:2]);
        if (r) begin
            ref_out = '0;
        end else if (e) begin
            if (!(re || we)) begin
                ref_out.rvalid = 1'b0;
                ref_out.mis    = 1'b0;
            end else if (hf ? a[0] : (a[1:0] != 2'b00)) begin
                ref_out.rvalid = 1'b0;
                ref_out.mis    = 1'b1;
            end else begin
                ref_out.mis    = 1'b0;
                ref_out.rvalid = re;
                if (re) begin
                    ref_out.rdata = ref_mem[idx];
                    ref_out.wc    = a[1];
                    ref_out.hwt   = hf;
                end
                if (we) begin
                    if (!hf)       ref_mem[idx]        = d;
                    else if (a[1]) ref_mem[idx][31:16] = d[15:0];
                    else           ref_mem[idx][15:0]  = d[15:0];
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic re, input logic we,
                        input logic hf, input logic [31:0] a, input logic [31:0] d);
        rst        = r;
        bus.en     = e;
        bus.mem_re = re;
        bus.mem_we = we;
        bus.half   = hf;
        bus.addr   = a;
        bus.wdata  = d;
        model(r, e, re, we, hf, a, d);
        exp_q.push_back(ref_out);
        @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] a);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, 32'h0);
    endtask

    always @(negedge clk) begin : monitor
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata",       bus.rdata,               e.rdata);
            chk("wc",          {31'b0, bus.wc},          {31'b0, e.wc});
            chk("half_word_t", {31'b0, bus.half_word_t}, {31'b0, e.hwt});
            chk("rvalid",      {31'b0, bus.rvalid},      {31'b0, e.rvalid});
            chk("misalign",    {31'b0, bus.misalign},    {31'b0, e.mis});
        end
    end

    initial begin
        logic [31:0] a;
        logic        hf;
        ref_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
        end
        ref_mem[0]  = 32'h0000_0000;
        ref_mem[8]  = 32'h1111_2222;
        ref_mem[12] = 32'hAAAA_5555;
        for (int i = 0; i < DEPTH; i++) begin
            dut.u_ram.mem_q[i] = ref_mem[i];
        end

        // reset with a store pending: write must be suppressed
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
        load_word(32'h0);

        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1234_5678);
        load_word(32'h10);

        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 32'h0000_8001);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22, 32'h0);

        load_word(32'h21);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h23, 32'hFFFF_FFFF);
        load_word(32'h20);

        // stall with stores toggling on the bus
        load_word(32'h10);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                 (i % 2 == 0) ? 32'h10 : 32'h14, $urandom);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        load_word(32'h10);
        load_word(32'h14);

        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0BAD_F00D);
        load_word(32'h30);
        load_word(32'h1000_0010);

        for (int i = 0; i < 600; i++) begin
            hf = 1'($urandom_range(0, 1));
            a  = {$urandom, 2'b00};
            a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
            else                           a[1:0] = hf ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hf, a, $urandom);
        end

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            load_word(32'(i * 4));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
